// File: rtl/i2c_dac_scheduler_pkg.sv
// Shared types, widths and I2C payload packing for the DAC scheduler.
// Ports: none (package).
package i2c_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SEND,
    GAP
  } state_t;

  localparam logic [7:0] DAC_ADDR_BYTE = 8'hC0;
  localparam int THRESH_W = 12;
  localparam int CMD_W = 3;

  function automatic logic [15:0] pack_data12(
    input logic [CMD_W-1:0] cmd
  );
    return {DAC_ADDR_BYTE, cmd, 5'b00000};
  endfunction

  function automatic logic [15:0] pack_data34(
    input logic [THRESH_W-1:0] thresh
  );
    return {thresh, 4'b0000};
  endfunction

endpackage

// File: rtl/i2c_dac_scheduler_if.sv
// Host write port and I2C4BYTES-facing bundle of the DAC scheduler.
// master: host side (drives WR_*); slave: scheduler side (drives I2C*, status).
interface i2c_dac_scheduler_if #(
  parameter int NCH = 2
);
  import i2c_sched_pkg::*;

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                WR_EN;
  logic [CW-1:0]       WR_CH;
  logic [THRESH_W-1:0] WR_THRESH;
  logic [CMD_W-1:0]    WR_CMD;
  logic [NCH-1:0]      I2CLINES;
  logic [15:0]         I2CDATA12;
  logic [15:0]         I2CDATA34;
  logic                I2CENABLE;
  logic                BUSY;
  logic                DONE;
  logic [CW-1:0]       DONE_CH;

  modport master (
    output WR_EN, WR_CH, WR_THRESH, WR_CMD,
    input  I2CLINES, I2CDATA12, I2CDATA34,
    input  I2CENABLE, BUSY, DONE, DONE_CH
  );

  modport slave (
    input  WR_EN, WR_CH, WR_THRESH, WR_CMD,
    output I2CLINES, I2CDATA12, I2CDATA34,
    output I2CENABLE, BUSY, DONE, DONE_CH
  );

endinterface

// File: rtl/i2c_dac_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first pending channel after ptr.
// In: pend[NCH], ptr. Out: gnt_idx, gnt_vld.
module rr_arbiter #(
  parameter int NCH = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] pend,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  logic [CW-1:0] kk;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    kk      = '0;
    for (int i = 1; i <= NCH; i++) begin
      kk = CW'((32'(ptr) + 32'(i)) % NCH);
      if (!gnt_vld && pend[kk]) begin
        gnt_vld = 1'b1;
        gnt_idx = kk;
      end
    end
  end

endmodule

// File: rtl/i2c_dac_scheduler.sv
// Per-channel DAC threshold store and round-robin I2C4BYTES sequencer.
// Ports: CLK, RESET (async high), bus (slave: host writes in, I2C/status out).
module i2c_dac_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NCH = 2,
  parameter int SETUP_CYCLES = 4,
  parameter int ENABLE_CYCLES = 1000,
  parameter int GAP_CYCLES = 16,
  parameter logic [31:0] REFRESH_CYCLES = 32'd0,
  parameter logic [THRESH_W-1:0] DEFAULT_THRESH = 12'd200,
  parameter logic [CMD_W-1:0] DEFAULT_CMD = 3'd3
) (
  input  logic CLK,
  input  logic RESET,
  i2c_dac_scheduler_if.slave bus
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] EN_LAST = 16'(ENABLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [31:0] REF_LAST = REFRESH_CYCLES - 32'd1;

  logic [THRESH_W-1:0] thresh_q [NCH];
  logic [CMD_W-1:0]    cmd_q [NCH];
  logic [NCH-1:0]      pend_q, pend_n;
  logic [CW-1:0]       ptr_q, cur_ch_q, gnt_idx;
  logic                gnt_vld;
  state_t              state_q, state_n;
  logic [15:0]         cnt_q, cnt_n;
  logic [31:0]         rcnt_q;
  logic                refresh_hit, wr_ok;
  logic                grant, done_n;

  logic [NCH-1:0] lines_q;
  logic [15:0]    d12_q, d34_q;
  logic           en_q, busy_q, done_q;
  logic [CW-1:0]  done_ch_q;

  assign bus.I2CLINES  = lines_q;
  assign bus.I2CDATA12 = d12_q;
  assign bus.I2CDATA34 = d34_q;
  assign bus.I2CENABLE = en_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.DONE_CH   = done_ch_q;

  assign wr_ok = bus.WR_EN && (32'(bus.WR_CH) < NCH);
  assign refresh_hit = (REFRESH_CYCLES != 32'd0)
                    && (rcnt_q == REF_LAST);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .pend    (pend_q),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    grant   = 1'b0;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant   = 1'b1;
          state_n = SETUP;
          cnt_n   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_n = SEND;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      SEND: begin
        if (cnt_q == EN_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Sets are applied after the grant clear so a colliding set wins.
  always_comb begin
    pend_n = pend_q;
    if (grant) pend_n[gnt_idx] = 1'b0;
    if (refresh_hit) pend_n = '1;
    if (wr_ok) pend_n[bus.WR_CH] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '1;
      ptr_q   <= CW'(NCH - 1);
      rcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      if (grant) ptr_q <= gnt_idx;
      if (REFRESH_CYCLES == 32'd0 || refresh_hit)
        rcnt_q <= '0;
      else
        rcnt_q <= rcnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        thresh_q[i] <= DEFAULT_THRESH;
        cmd_q[i]    <= DEFAULT_CMD;
      end
    end else if (wr_ok) begin
      thresh_q[bus.WR_CH] <= bus.WR_THRESH;
      cmd_q[bus.WR_CH]    <= bus.WR_CMD;
    end
  end

  // Lines/data latch only on grant and then hold through IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lines_q   <= '0;
      d12_q     <= '0;
      d34_q     <= '0;
      cur_ch_q  <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      if (grant) begin
        lines_q  <= NCH'(1) << gnt_idx;
        d12_q    <= pack_data12(cmd_q[gnt_idx]);
        d34_q    <= pack_data34(thresh_q[gnt_idx]);
        cur_ch_q <= gnt_idx;
      end
      en_q   <= (state_n == SEND);
      busy_q <= (state_n != IDLE);
      done_q <= done_n;
      if (done_n) done_ch_q <= cur_ch_q;
    end
  end

endmodule

// File: tb/tb_i2c_dac_scheduler.sv
// Directed bench for i2c_dac_scheduler: reset sequence, writes, arbitration,
// in-flight writes, async reset, and refresh on a second instance.
module tb_i2c_dac_scheduler;

  logic clk;
  logic rst;
  logic ref_rst;
  int   nvec;
  int   nerr;
  int   cyc;
  int   ref_dones;
  int   snap0, snap1, snap2, snap3;

  i2c_dac_scheduler_if #(.NCH(2)) bus ();
  i2c_dac_scheduler_if #(.NCH(2)) rbus ();

  i2c_dac_scheduler u_dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  i2c_dac_scheduler #(
    .REFRESH_CYCLES (32'd5000)
  ) u_ref (
    .CLK   (clk),
    .RESET (ref_rst),
    .bus   (rbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge ref_rst) begin
    if (ref_rst) begin
      cyc       <= 0;
      ref_dones <= 0;
      snap0     <= -1;
      snap1     <= -1;
      snap2     <= -1;
      snap3     <= -1;
    end else begin
      cyc <= cyc + 1;
      if (rbus.DONE) ref_dones <= ref_dones + 1;
      if (cyc == 4500) snap0 <= ref_dones;
      if (cyc == 7500) snap1 <= ref_dones;
      if (cyc == 9900) snap2 <= ref_dones;
      if (cyc == 12500) snap3 <= ref_dones;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic ch, input logic [11:0] th,
                    input logic [2:0] cm);
    bus.WR_EN     = 1'b1;
    bus.WR_CH     = ch;
    bus.WR_THRESH = th;
    bus.WR_CMD    = cm;
    @(negedge clk);
    bus.WR_EN = 1'b0;
  endtask

  // One full transaction seen from the current negedge: rise latency,
  // payload, enable width, gap length, DONE_CH, frozen payload.
  task automatic txn(input string tag, input logic [1:0] lines,
                     input logic [15:0] d12, input logic [15:0] d34,
                     input logic ch, input int nmw,
                     input logic ca, input logic [11:0] ta,
                     input logic [2:0] ma,
                     input logic cb, input logic [11:0] tb2,
                     input logic [2:0] mb);
    int n;
    int w;
    n = 0;
    while (bus.I2CENABLE !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rise"}, n, 5);
    chk({tag, "_lines"}, 32'(bus.I2CLINES), 32'(lines));
    chk({tag, "_d12"}, 32'(bus.I2CDATA12), 32'(d12));
    chk({tag, "_d34"}, 32'(bus.I2CDATA34), 32'(d34));
    w = 0;
    while (bus.I2CENABLE === 1'b1 && w < 1100) begin
      if (w == 0 && nmw > 0) begin
        bus.WR_EN = 1'b1; bus.WR_CH = ca;
        bus.WR_THRESH = ta; bus.WR_CMD = ma;
      end else if (w == 1 && nmw > 1) begin
        bus.WR_EN = 1'b1; bus.WR_CH = cb;
        bus.WR_THRESH = tb2; bus.WR_CMD = mb;
      end else begin
        bus.WR_EN = 1'b0;
      end
      @(negedge clk);
      w++;
    end
    bus.WR_EN = 1'b0;
    chk({tag, "_width"}, w, 1000);
    n = 0;
    while (bus.DONE !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gap"}, n, 16);
    chk({tag, "_done_ch"}, 32'(bus.DONE_CH), 32'(ch));
    chk({tag, "_hold_d34"}, 32'(bus.I2CDATA34), 32'(d34));
    chk({tag, "_hold_lines"}, 32'(bus.I2CLINES), 32'(lines));
  endtask

  initial begin
    int n;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    ref_rst = 1'b1;
    bus.WR_EN = 1'b0; bus.WR_CH = '0;
    bus.WR_THRESH = '0; bus.WR_CMD = '0;
    rbus.WR_EN = 1'b0; rbus.WR_CH = '0;
    rbus.WR_THRESH = '0; rbus.WR_CMD = '0;
    repeat (3) @(negedge clk);

    chk("rst_lines", 32'(bus.I2CLINES), 0);
    chk("rst_d12", 32'(bus.I2CDATA12), 0);
    chk("rst_d34", 32'(bus.I2CDATA34), 0);
    chk("rst_en", 32'(bus.I2CENABLE), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_done_ch", 32'(bus.DONE_CH), 0);

    rst = 1'b0;
    ref_rst = 1'b0;
    txn("s1a", 2'b01, 16'hC060, 16'h0C80, 1'b0,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);
    txn("s1b", 2'b10, 16'hC060, 16'h0C80, 1'b1,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);
    @(negedge clk);
    chk("s1_done_pulse", 32'(bus.DONE), 0);
    chk("s1_idle_busy", 32'(bus.BUSY), 0);
    chk("s1_idle_lines", 32'(bus.I2CLINES), 32'h2);

    repeat (3) @(negedge clk);
    wr(1'b1, 12'hABC, 3'd5);
    txn("s2", 2'b10, 16'hC0A0, 16'hABC0, 1'b1,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);

    repeat (3) @(negedge clk);
    wr(1'b0, 12'h456, 3'd3);
    txn("s3a", 2'b01, 16'hC060, 16'h4560, 1'b0,
        1, 1'b0, 12'h111, 3'd3, 1'b0, 12'h0, 3'd0);
    txn("s3b", 2'b01, 16'hC060, 16'h1110, 1'b0,
        2, 1'b0, 12'h222, 3'd1, 1'b1, 12'h333, 3'd7);
    txn("s4a", 2'b10, 16'hC0E0, 16'h3330, 1'b1,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);
    txn("s4b", 2'b01, 16'hC020, 16'h2220, 1'b0,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);
    @(negedge clk);
    chk("s4_idle_busy", 32'(bus.BUSY), 0);

    repeat (2) @(negedge clk);
    wr(1'b1, 12'h777, 3'd2);
    n = 0;
    while (bus.I2CENABLE !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s6_rise", n, 5);
    repeat (100) @(negedge clk);
    chk("s6_pre_en", 32'(bus.I2CENABLE), 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_en", 32'(bus.I2CENABLE), 0);
    chk("s6_async_busy", 32'(bus.BUSY), 0);
    chk("s6_async_lines", 32'(bus.I2CLINES), 0);
    @(negedge clk);
    rst = 1'b0;
    txn("s6a", 2'b01, 16'hC060, 16'h0C80, 1'b0,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);
    txn("s6b", 2'b10, 16'hC060, 16'h0C80, 1'b1,
        0, 1'b0, 12'h0, 3'd0, 1'b0, 12'h0, 3'd0);

    n = 0;
    while (cyc < 12600 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("ref_budget", 32'(cyc >= 12600), 1);
    chk("ref_t4500", snap0, 2);
    chk("ref_t7500", snap1, 4);
    chk("ref_t9900", snap2, 4);
    chk("ref_t12500", snap3, 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
